decode_stage: RTL and testbench

- Registered, handshaked instruction-decode stage for the RV32I pipeline. Sits between the IF/ID boundary and the register file / Dec_ALU boundary.
- Decodes all RV32I base formats (R/I/S/B/U/J) and generates sign-extended immediates.
- Flags illegal encodings and buffers one extra instruction in a skid register so both sides can stall independently.

---
 rtl/decode_stage_pkg.sv | 50 +++++
 rtl/decode_stage_decode_logic.sv | 113 +++++++++++
 rtl/decode_stage.sv | 113 +++++++++++
 tb/tb_decode_stage.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_stage_pkg.sv
// Shared constants and types for the RV32I decode stage: opcodes, the NOP
// encoding, the instruction-format enum and the registered decode bundle.
package decode_stage_pkg;

    localparam int P_XLEN       = 32;
    localparam int P_REG_ADDR_W = 5;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_NOP    = 7'h00;

    // NONE is encoded as zero so a cleared bundle reads as "no instruction".
    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_R    = 3'd1,
        FMT_I    = 3'd2,
        FMT_S    = 3'd3,
        FMT_B    = 3'd4,
        FMT_U    = 3'd5,
        FMT_J    = 3'd6
    } inst_fmt_e;

    typedef struct packed {
        logic [P_XLEN-1:0]       pc;
        logic [6:0]              opcode;
        logic [2:0]              func3;
        logic [6:0]              func7;
        logic [P_REG_ADDR_W-1:0] rs1;
        logic [P_REG_ADDR_W-1:0] rs2;
        logic [P_REG_ADDR_W-1:0] rd;
        logic                    reg_we;
        logic [P_XLEN-1:0]       imm;
        inst_fmt_e               fmt;
        logic                    illegal;
    } bundle_t;

    localparam int BUNDLE_W = $bits(bundle_t);

    function automatic logic [P_XLEN-1:0] sext32(input logic [31:0] v);
        return P_XLEN'({{P_XLEN{v[31]}}, v});
    endfunction

endpackage

// File: rtl/decode_stage_decode_logic.sv
// Pure combinational RV32I instruction-to-bundle decoder.
// Define DECODE_RV32M_EN to accept OP with func7 0000001 (M extension) as legal.
module decode_stage_decode_logic
    import decode_stage_pkg::*;
(
    input  logic [31:0]       i_inst,
    input  logic [P_XLEN-1:0] i_pc,
    output bundle_t           o_bundle
);

    logic [6:0]              w_opc;
    logic [2:0]              w_f3;
    logic [6:0]              w_f7;
    logic [P_REG_ADDR_W-1:0] w_rs1;
    logic [P_REG_ADDR_W-1:0] w_rs2;
    logic [P_REG_ADDR_W-1:0] w_rd;
    logic [31:0]             w_imm_i;

    assign w_opc   = i_inst[6:0];
    assign w_f3    = i_inst[14:12];
    assign w_f7    = i_inst[31:25];
    assign w_rs1   = i_inst[19:15];
    assign w_rs2   = i_inst[24:20];
    assign w_rd    = i_inst[11:7];
    assign w_imm_i = {{20{i_inst[31]}}, i_inst[31:20]};

    inst_fmt_e   w_fmt;
    logic        w_legal;
    logic [31:0] w_imm32;
    logic        w_uses_rs1;
    logic        w_uses_rs2;
    logic        w_writes_rd;

    always_comb begin
        w_fmt   = FMT_NONE;
        w_legal = 1'b0;
        w_imm32 = '0;
        case (w_opc)
            OPC_LUI, OPC_AUIPC: begin
                w_fmt   = FMT_U;
                w_legal = 1'b1;
                w_imm32 = {i_inst[31:12], 12'b0};
            end
            OPC_JAL: begin
                w_fmt   = FMT_J;
                w_legal = 1'b1;
                w_imm32 = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12],
                           i_inst[20], i_inst[30:21], 1'b0};
            end
            OPC_JALR: begin
                w_fmt   = FMT_I;
                w_legal = (w_f3 == 3'b000);
                w_imm32 = w_imm_i;
            end
            OPC_BRANCH: begin
                w_fmt   = FMT_B;
                w_legal = !(w_f3 inside {3'b010, 3'b011});
                w_imm32 = {{19{i_inst[31]}}, i_inst[31], i_inst[7],
                           i_inst[30:25], i_inst[11:8], 1'b0};
            end
            OPC_LOAD: begin
                w_fmt   = FMT_I;
                w_legal = w_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
                w_imm32 = w_imm_i;
            end
            OPC_STORE: begin
                w_fmt   = FMT_S;
                w_legal = w_f3 inside {3'b000, 3'b001, 3'b010};
                w_imm32 = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
            end
            OPC_OP_IMM: begin
                w_fmt   = FMT_I;
                w_imm32 = w_imm_i;
                // Shift-immediates reuse the upper immediate bits as func7.
                case (w_f3)
                    3'b001:  w_legal = (w_f7 == 7'b0000000);
                    3'b101:  w_legal = (w_f7 == 7'b0000000) || (w_f7 == 7'b0100000);
                    default: w_legal = 1'b1;
                endcase
            end
            OPC_OP: begin
                w_fmt   = FMT_R;
                w_legal = (w_f7 == 7'b0000000)
                       || ((w_f7 == 7'b0100000) && (w_f3 inside {3'b000, 3'b101}))
`ifdef DECODE_RV32M_EN
                       || (w_f7 == 7'b0000001)
`endif
                       ;
            end
            default: ;
        endcase
    end

    assign w_uses_rs1  = w_legal && (w_fmt inside {FMT_R, FMT_I, FMT_S, FMT_B});
    assign w_uses_rs2  = w_legal && (w_fmt inside {FMT_R, FMT_S, FMT_B});
    assign w_writes_rd = w_legal && (w_fmt inside {FMT_R, FMT_I, FMT_U, FMT_J}) && (w_rd != '0);

    always_comb begin
        o_bundle         = '0;
        o_bundle.pc      = i_pc;
        o_bundle.opcode  = w_legal ? w_opc : OPC_NOP;
        o_bundle.func3   = w_f3;
        o_bundle.func7   = w_f7;
        o_bundle.rs1     = w_uses_rs1 ? w_rs1 : '0;
        o_bundle.rs2     = w_uses_rs2 ? w_rs2 : '0;
        o_bundle.rd      = w_writes_rd ? w_rd : '0;
        o_bundle.reg_we  = w_writes_rd;
        o_bundle.imm     = w_legal ? sext32(w_imm32) : '0;
        o_bundle.fmt     = w_legal ? w_fmt : FMT_NONE;
        o_bundle.illegal = !w_legal;
    end

endmodule

// File: rtl/decode_stage.sv
// Registered, handshaked RV32I decode stage with a one-entry skid buffer.
// Optional M-extension decode is enabled by defining DECODE_RV32M_EN.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int XLEN       = P_XLEN,
    parameter int REG_ADDR_W = P_REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  flush,
    input  logic                  inValid,
    output logic                  inReady,
    input  logic [31:0]           inInst,
    input  logic [XLEN-1:0]       inPc,
    output logic                  outValid,
    input  logic                  outReady,
    output logic [XLEN-1:0]       outPc,
    output logic [REG_ADDR_W-1:0] readAddr1,
    output logic [REG_ADDR_W-1:0] readAddr2,
    output logic [REG_ADDR_W-1:0] writeAddr,
    output logic                  regWriteEnable,
    output logic [6:0]            ALUopcode,
    output logic [2:0]            ALUFunc3,
    output logic [6:0]            ALUFunc7,
    output logic [XLEN-1:0]       immValue,
    output logic [2:0]            instFormat,
    output logic                  illegal
);

    bundle_t w_dec;

    decode_stage_decode_logic u_decode (
        .i_inst   (inInst),
        .i_pc     (inPc),
        .o_bundle (w_dec)
    );

    bundle_t             r_out;
    logic                r_out_valid;
    logic [BUNDLE_W-1:0] r_skid;
    logic                r_skid_valid;
    logic                r_in_ready;

    bundle_t             w_out_next;
    logic                w_out_valid_next;
    logic [BUNDLE_W-1:0] w_skid_next;
    logic                w_skid_valid_next;
    logic                w_in_ready_next;
    logic                w_in_fire;
    logic                w_out_fire;

    assign w_in_fire  = inValid && r_in_ready;
    assign w_out_fire = r_out_valid && outReady;

    always_comb begin
        w_out_next        = r_out;
        w_out_valid_next  = r_out_valid;
        w_skid_next       = r_skid;
        w_skid_valid_next = r_skid_valid;
        if (flush) begin
            w_out_valid_next  = 1'b0;
            w_skid_valid_next = 1'b0;
        end else if (!r_out_valid || w_out_fire) begin
            // Skid is always older than anything arriving now; inReady is low while it is full.
            if (r_skid_valid) begin
                w_out_next        = bundle_t'(r_skid);
                w_out_valid_next  = 1'b1;
                w_skid_valid_next = 1'b0;
            end else if (w_in_fire) begin
                w_out_next       = w_dec;
                w_out_valid_next = 1'b1;
            end else begin
                w_out_valid_next = 1'b0;
            end
        end else if (w_in_fire) begin
            w_skid_next       = w_dec;
            w_skid_valid_next = 1'b1;
        end
        w_in_ready_next = !w_skid_valid_next;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_out        <= '0;
            r_out_valid  <= 1'b0;
            r_skid       <= '0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b0;
        end else begin
            r_out        <= w_out_next;
            r_out_valid  <= w_out_valid_next;
            r_skid       <= w_skid_next;
            r_skid_valid <= w_skid_valid_next;
            r_in_ready   <= w_in_ready_next;
        end
    end

    assign inReady        = r_in_ready;
    assign outValid       = r_out_valid;
    assign outPc          = r_out.pc;
    assign readAddr1      = r_out.rs1;
    assign readAddr2      = r_out.rs2;
    assign writeAddr      = r_out.rd;
    assign regWriteEnable = r_out.reg_we;
    assign ALUopcode      = r_out.opcode;
    assign ALUFunc3       = r_out.func3;
    assign ALUFunc7       = r_out.func7;
    assign immValue       = r_out.imm;
    assign instFormat     = r_out.fmt;
    assign illegal        = r_out.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: hand-computed expected bundles are queued
// on input transfer and compared on output transfer.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        flush = 1'b0;
    logic        inValid = 1'b0;
    logic        inReady;
    logic [31:0] inInst = '0;
    logic [31:0] inPc = '0;
    logic        outValid;
    logic        outReady = 1'b0;
    logic [31:0] outPc;
    logic [4:0]  readAddr1, readAddr2, writeAddr;
    logic        regWriteEnable;
    logic [6:0]  ALUopcode;
    logic [2:0]  ALUFunc3;
    logic [6:0]  ALUFunc7;
    logic [31:0] immValue;
    logic [2:0]  instFormat;
    logic        illegal;

    decode_stage dut (
        .clk(clk), .resetN(resetN), .flush(flush),
        .inValid(inValid), .inReady(inReady), .inInst(inInst), .inPc(inPc),
        .outValid(outValid), .outReady(outReady), .outPc(outPc),
        .readAddr1(readAddr1), .readAddr2(readAddr2), .writeAddr(writeAddr),
        .regWriteEnable(regWriteEnable), .ALUopcode(ALUopcode),
        .ALUFunc3(ALUFunc3), .ALUFunc7(ALUFunc7), .immValue(immValue),
        .instFormat(instFormat), .illegal(illegal)
    );

    always #5 clk = ~clk;

    localparam logic [2:0] F_NONE = 3'd0, F_R = 3'd1, F_I = 3'd2, F_S = 3'd3,
                           F_B = 3'd4, F_U = 3'd5, F_J = 3'd6;

    typedef struct {
        logic [31:0] inst;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rs1, rs2, rd;
        logic        we;
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] pc;
    } exp_t;

    vec_t tbl [14];
    exp_t sb [$];
    int   checks = 0;
    int   failures = 0;
    int   cur_idx = 0;
    int   seq = 0;
    logic last_in_fire = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] inst, input logic [6:0] opc,
                                input logic [2:0] f3, input logic [6:0] f7,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic we,
                                input logic [31:0] imm, input logic [2:0] fmt);
        vec_t v;
        v.inst = inst; v.opc = opc; v.f3 = f3; v.f7 = f7;
        v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.we = we;
        v.imm = imm; v.fmt = fmt; v.ill = 1'b0;
        return v;
    endfunction

    function automatic vec_t mk_ill(input logic [31:0] inst);
        vec_t v;
        v = mk(inst, 7'h00, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, F_NONE);
        v.ill = 1'b1;
        return v;
    endfunction

    // One clock: sample handshakes mid-cycle, score, then step past the edge.
    task automatic tick();
        exp_t e;
        vec_t v;
        logic in_f, out_f;
        string t;
        @(negedge clk);
        in_f  = inValid && inReady;
        out_f = outValid && outReady;
        if (flush) begin
            sb.delete();
        end else begin
            if (out_f) begin
                check("sb_nonempty", 64'(sb.size() != 0), 64'(1));
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    v = tbl[e.idx];
                    t = $sformatf("v%0d_pc%0h", e.idx, e.pc);
                    check({t, "_pc"},   64'(outPc), 64'(e.pc));
                    check({t, "_opc"},  64'(ALUopcode), 64'(v.opc));
                    if (!v.ill) begin
                        check({t, "_f3"}, 64'(ALUFunc3), 64'(v.f3));
                        check({t, "_f7"}, 64'(ALUFunc7), 64'(v.f7));
                    end
                    check({t, "_ra1"},  64'(readAddr1), 64'(v.rs1));
                    check({t, "_ra2"},  64'(readAddr2), 64'(v.rs2));
                    check({t, "_wa"},   64'(writeAddr), 64'(v.rd));
                    check({t, "_we"},   64'(regWriteEnable), 64'(v.we));
                    check({t, "_imm"},  64'(immValue), 64'(v.imm));
                    check({t, "_fmt"},  64'(instFormat), 64'(v.fmt));
                    check({t, "_ill"},  64'(illegal), 64'(v.ill));
                    $display("txn out idx=%0d pc=0x%08h inst=0x%08h illegal=%0d", e.idx, outPc, v.inst, illegal);
                end
            end
            if (in_f) begin
                sb.push_back('{idx: cur_idx, pc: inPc});
            end
        end
        last_in_fire = in_f && !flush;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int idx);
        cur_idx = idx;
        inInst  = tbl[idx].inst;
        inPc    = 32'h100 + 32'(seq * 4);
        inValid = 1'b1;
    endtask

    task automatic send(input int idx);
        int n;
        drive(idx);
        n = 0;
        do begin
            tick();
            n++;
        end while (!last_in_fire && n < 50);
        check($sformatf("accept_v%0d", idx), 64'(last_in_fire), 64'(1));
        seq++;
        inValid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || outValid) && n < 30) begin
            tick();
            n++;
        end
        check("drain_empty", 64'(sb.size()), 64'(0));
        check("drain_idle", 64'(outValid), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pc_a;
        int held;
        int n;

        tbl[0]  = mk(32'h00500093, 7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 1'b1, 32'h00000005, F_I);
        tbl[1]  = mk(32'hFE20AE23, 7'h23, 3'd2, 7'h7F, 5'd1, 5'd2, 5'd0, 1'b0, 32'hFFFFFFFC, F_S);
        tbl[2]  = mk(32'h123452B7, 7'h37, 3'd5, 7'h09, 5'd0, 5'd0, 5'd5, 1'b1, 32'h12345000, F_U);
        tbl[3]  = mk(32'hFE208CE3, 7'h63, 3'd0, 7'h7F, 5'd1, 5'd2, 5'd0, 1'b0, 32'hFFFFFFF8, F_B);
        tbl[4]  = mk(32'h010000EF, 7'h6F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 1'b1, 32'h00000010, F_J);
        tbl[5]  = mk(32'h4031D213, 7'h13, 3'd5, 7'h20, 5'd3, 5'd0, 5'd4, 1'b1, 32'h00000403, F_I);
        tbl[6]  = mk(32'h00000013, 7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 1'b0, 32'h00000000, F_I);
        tbl[7]  = mk_ill(32'hFFFFFFFF);
        tbl[8]  = mk_ill(32'h400010B3);
        tbl[9]  = mk_ill(32'h00002063);
`ifdef DECODE_RV32M_EN
        tbl[10] = mk(32'h022081B3, 7'h33, 3'd0, 7'h01, 5'd1, 5'd2, 5'd3, 1'b1, 32'h00000000, F_R);
`else
        tbl[10] = mk_ill(32'h022081B3);
`endif
        tbl[11] = mk(32'h407302B3, 7'h33, 3'd0, 7'h20, 5'd6, 5'd7, 5'd5, 1'b1, 32'h00000000, F_R);
        tbl[12] = mk(32'h00812383, 7'h03, 3'd2, 7'h00, 5'd2, 5'd0, 5'd7, 1'b1, 32'h00000008, F_I);
        tbl[13] = mk_ill(32'h000290E7);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_outValid", 64'(outValid), 64'(0));
        check("rst_inReady",  64'(inReady), 64'(0));
        check("rst_opcode",   64'(ALUopcode), 64'(0));
        check("rst_fmt",      64'(instFormat), 64'(F_NONE));
        check("rst_imm",      64'(immValue), 64'(0));
        check("rst_we",       64'(regWriteEnable), 64'(0));
        check("rst_illegal",  64'(illegal), 64'(0));
        check("rst_pc",       64'(outPc), 64'(0));
        @(negedge clk);
        resetN = 1'b1;
        @(posedge clk);
        #1;
        check("rel_inReady", 64'(inReady), 64'(1));

        // Streaming with the sink always ready
        outReady = 1'b1;
        send(0);
        check("lat_outValid", 64'(outValid), 64'(1));
        for (int i = 1; i < 14; i++) send(i);
        drain();

        // Backpressure: two accepted, third held upstream
        outReady = 1'b0;
        pc_a = 32'h100 + 32'(seq * 4);
        send(0);
        send(1);
        check("bp_inReady", 64'(inReady), 64'(0));
        drive(2);
        held = 0;
        repeat (3) begin
            tick();
            if (last_in_fire) held++;
        end
        check("bp_no_accept", 64'(held), 64'(0));
        check("bp_hold_valid", 64'(outValid), 64'(1));
        check("bp_hold_pc", 64'(outPc), 64'(pc_a));
        outReady = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!last_in_fire && n < 20);
        check("bp_third_accept", 64'(last_in_fire), 64'(1));
        seq++;
        inValid = 1'b0;
        drain();

        // Flush with both entries full, input offered in the same cycle
        outReady = 1'b0;
        send(3);
        send(4);
        drive(5);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        inValid = 1'b0;
        check("fl_outValid", 64'(outValid), 64'(0));
        check("fl_inReady", 64'(inReady), 64'(1));

        // Flush with only the output entry full: the offered input must be dropped
        send(6);
        drive(7);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        inValid = 1'b0;
        check("fl2_outValid", 64'(outValid), 64'(0));
        tick();
        tick();
        check("fl2_stays_empty", 64'(outValid), 64'(0));
        outReady = 1'b1;
        send(11);
        drain();

        // Asynchronous reset while stalled with both entries full
        outReady = 1'b0;
        send(0);
        send(1);
        #3;
        resetN = 1'b0;
        #1;
        check("ar_outValid", 64'(outValid), 64'(0));
        check("ar_inReady", 64'(inReady), 64'(0));
        sb.delete();
        @(negedge clk);
        resetN = 1'b1;
        @(posedge clk);
        #1;
        check("ar_rel_inReady", 64'(inReady), 64'(1));
        check("ar_rel_outValid", 64'(outValid), 64'(0));

        // M-extension encoding after recovery
        outReady = 1'b1;
        send(10);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
